keypad_scan_controller: RTL and testbench

Sequencing controller for the 4x4 hexadecimal keypad on the secondary system.
- Drives the active-low row strobes and synchronizes the active-low column inputs.
- Debounces press and release, then encodes the key into a 4-bit code and an ASCII byte.
- Hands the byte to the UART transmitter through a one-entry valid/ready buffer.
- Replaces free-running row scanning: the scan freezes on the pressed row until the key is released.

---
 rtl/keypad_pkg.sv | 62 ++++++
 rtl/keypad_scan_controller_if.sv | 12 +
 rtl/keypad_stable_timer.sv | 38 +++
 rtl/keypad_scan_controller.sv | 155 +++++++++++++++
 tb/tb_keypad_scan_controller.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and lookup helpers for the 4x4 hex keypad scanner.
// Covers the FSM states, row strobe patterns, the key map and the hex-to-ASCII conversion.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    PRESS_DB,
    EMIT,
    HELD,
    RELEASE_DB
  } state_t;

  localparam logic [3:0] ROW0_STROBE = 4'b1110;
  localparam logic [3:0] ROW1_STROBE = 4'b1101;
  localparam logic [3:0] ROW2_STROBE = 4'b1011;
  localparam logic [3:0] ROW3_STROBE = 4'b0111;

  function automatic logic [3:0] row_strobe(input logic [1:0] row);
    case (row)
      2'd0:    return ROW0_STROBE;
      2'd1:    return ROW1_STROBE;
      2'd2:    return ROW2_STROBE;
      default: return ROW3_STROBE;
    endcase
  endfunction

  // Lowest active column index wins when several columns are pressed together.
  function automatic logic [1:0] lowest_col(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  // Row 3 carries '*' as E and '#' as F.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  function automatic logic [7:0] code_to_ascii(input logic [3:0] code);
    if (code < 4'd10) return 8'h30 + {4'h0, code};
    else              return 8'h37 + {4'h0, code};
  endfunction

endpackage

// File: rtl/keypad_scan_controller_if.sv
// Valid/ready byte channel from the keypad controller to the external UART transmitter.
interface keypad_scan_controller_if;
  import keypad_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/keypad_stable_timer.sv
// Counts consecutive cycles with an unchanged input; done once N equal cycles have been seen.
// Shared between press and release debounce, so clear re-arms it on the current value.
module keypad_stable_timer
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [WIDTH-1:0] ref_reg;
  logic [CW-1:0]    cnt_reg;

  assign changed = (value != ref_reg);
  assign done    = !clear && !changed && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_reg <= '0;
      cnt_reg <= '0;
    end else if (clear || changed) begin
      ref_reg <= value;
      cnt_reg <= '0;
    end else if (cnt_reg != LAST) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: row strobing, column sync, press/release debounce, key encoding
// and a one-entry valid/ready buffer feeding the UART. The scan freezes while a key is held.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 27_000,
  parameter int DEBOUNCE_CYCLES = 540_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [3:0]                      columnas,
  output logic [3:0]                      filas,
  output logic [3:0]                      key_code,
  output logic                            key_strobe,
  keypad_scan_controller_if.master        tx,
  output logic                            overrun
);

  localparam int DW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [1:0]    row_reg, row_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [3:0]    col_meta_reg, col_s_reg;
  logic [3:0]    pattern_reg;
  logic [3:0]    filas_reg;
  logic [3:0]    key_code_reg;
  logic          key_strobe_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_valid_reg;
  logic          overrun_reg;

  logic [3:0] col_n;
  logic       timer_clear;
  logic       col_changed;
  logic       stable_done;
  logic       emit;
  logic       accept;
  logic [3:0] emit_code;

  assign col_n     = ~col_s_reg;
  assign emit      = (state_reg == EMIT);
  assign accept    = tx_valid_reg & tx.tx_ready;
  assign emit_code = keymap(row_reg, lowest_col(pattern_reg));

  keypad_stable_timer #(
    .WIDTH (4),
    .N     (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .value   (col_n),
    .changed (col_changed),
    .done    (stable_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_reg <= 4'hF;
      col_s_reg    <= 4'hF;
    end else begin
      col_meta_reg <= columnas;
      col_s_reg    <= col_meta_reg;
    end
  end

  // The timer is held clear outside the debounce states so it latches the pattern
  // (or the all-released value) on the cycle the FSM enters PRESS_DB/RELEASE_DB.
  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    dwell_next  = '0;
    timer_clear = 1'b1;
    case (state_reg)
      SCAN: begin
        if (col_n != 4'h0) begin
          state_next = PRESS_DB;
        end else if (dwell_reg == DWELL_LAST) begin
          row_next = row_reg + 2'd1;
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end
      PRESS_DB: begin
        timer_clear = 1'b0;
        if (col_changed)      state_next = SCAN;
        else if (stable_done) state_next = EMIT;
      end
      EMIT: state_next = HELD;
      HELD: begin
        if (col_n == 4'h0) state_next = RELEASE_DB;
      end
      RELEASE_DB: begin
        timer_clear = 1'b0;
        if (col_changed) begin
          state_next = HELD;
        end else if (stable_done) begin
          state_next = SCAN;
          row_next   = row_reg + 2'd1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= SCAN;
      row_reg     <= 2'd0;
      dwell_reg   <= '0;
      filas_reg   <= ROW0_STROBE;
      pattern_reg <= 4'h0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      dwell_reg <= dwell_next;
      filas_reg <= row_strobe(row_next);
      if (state_reg == SCAN && col_n != 4'h0) pattern_reg <= col_n;
    end
  end

  // A byte accepted in the EMIT cycle frees the slot, so the new byte still loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code_reg   <= 4'h0;
      key_strobe_reg <= 1'b0;
      tx_data_reg    <= 8'h30;
      tx_valid_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      key_strobe_reg <= emit;
      if (emit) begin
        key_code_reg <= emit_code;
        if (!tx_valid_reg || accept) begin
          tx_data_reg  <= code_to_ascii(emit_code);
          tx_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (accept) begin
        tx_valid_reg <= 1'b0;
      end
    end
  end

  assign filas       = filas_reg;
  assign key_code    = key_code_reg;
  assign key_strobe  = key_strobe_reg;
  assign overrun     = overrun_reg;
  assign tx.tx_data  = tx_data_reg;
  assign tx.tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a keypad model answers the row strobes, a forked monitor
// checks key_code on each strobe and tx_data on each accepted byte against queued expectations.
module tb_keypad_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] key_code;
  logic       key_strobe;
  logic       overrun;

  logic       press_en;
  logic [1:0] press_row;
  logic [3:0] press_mask;
  logic       force_en;
  logic [3:0] force_mask;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic       exp_overrun;
  logic [3:0] exp_code[$];
  logic [7:0] exp_tx[$];

  typedef struct {
    logic [1:0] row;
    logic [3:0] mask;
    logic [3:0] code;
    logic [7:0] ascii;
  } vec_t;
  vec_t vecs[10];

  keypad_scan_controller_if kif();

  keypad_scan_controller #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .columnas   (columnas),
    .filas      (filas),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .tx         (kif),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // A pressed key only pulls its column low while its row strobe is active.
  always_comb begin
    columnas = 4'hF;
    if (force_en)                                    columnas = ~force_mask;
    else if (press_en && filas[press_row] == 1'b0)   columnas = ~press_mask;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press_key(input logic [1:0] r, input logic [3:0] m,
                           input logic [3:0] code, input logic [7:0] asc);
    int   prev;
    logic seen;
    exp_code.push_back(code);
    if (exp_tx.size() == 0) exp_tx.push_back(asc);
    else                    exp_overrun = 1'b1;
    prev       = strobe_cnt;
    press_row  = r;
    press_mask = m;
    press_en   = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #2;
      if (strobe_cnt != prev) seen = 1'b1;
    end
    check("strobe_seen", seen, 1'b1);
    repeat (10) @(negedge clk);
    press_en = 1'b0;
    repeat (25) @(negedge clk);
    check("one_strobe", strobe_cnt - prev, 1);
    $display("press row %0d mask %b -> key_code %h tx_data %h overrun %b",
             r, m, key_code, kif.tx_data, overrun);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_f;
    logic       found;
    int         prev;

    reset = 1'b0; kif.tx_ready = 1'b1;
    press_en = 1'b0; press_row = 2'd0; press_mask = 4'h0;
    force_en = 1'b0; force_mask = 4'h0;
    exp_overrun = 1'b0;

    vecs[0] = '{2'd1, 4'b0010, 4'h5, 8'h35};
    vecs[1] = '{2'd0, 4'b1000, 4'hA, 8'h41};
    vecs[2] = '{2'd2, 4'b0001, 4'h7, 8'h37};
    vecs[3] = '{2'd3, 4'b1100, 4'hF, 8'h46};
    vecs[4] = '{2'd3, 4'b0001, 4'hE, 8'h45};
    vecs[5] = '{2'd3, 4'b0010, 4'h0, 8'h30};
    vecs[6] = '{2'd1, 4'b1000, 4'hB, 8'h42};
    vecs[7] = '{2'd2, 4'b0100, 4'h9, 8'h39};
    vecs[8] = '{2'd3, 4'b1000, 4'hD, 8'h44};
    vecs[9] = '{2'd0, 4'b0110, 4'h2, 8'h32};

    fork
      forever begin
        @(negedge clk); #1;
        if (reset) begin
          if (key_strobe) begin
            strobe_cnt++;
            if (exp_code.size() == 0) check("unexpected_strobe", key_strobe, 1'b0);
            else                      check("key_code", key_code, exp_code.pop_front());
          end
          if (kif.tx_valid && kif.tx_ready) begin
            if (exp_tx.size() == 0) check("unexpected_tx", kif.tx_valid, 1'b0);
            else                    check("tx_data", kif.tx_data, exp_tx.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_filas", filas, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_strobe", key_strobe, 1'b0);
    check("rst_tx_data", kif.tx_data, 8'h30);
    check("rst_tx_valid", kif.tx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    reset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_f = ~(4'b0001 << ((k / 4) % 4));
      check("idle_filas", filas, exp_f);
      check("idle_tx_valid", kif.tx_valid, 1'b0);
    end

    for (int v = 0; v < 10; v++) begin
      press_key(vecs[v].row, vecs[v].mask, vecs[v].code, vecs[v].ascii);
      check("tbl_tx_valid", kif.tx_valid, 1'b0);
      check("tbl_overrun", overrun, exp_overrun);
    end

    // Three-cycle glitch on column 0 at the start of row 0: must not emit, scan stays on row 0.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (filas == 4'b0111) found = 1'b1;
    end
    check("wait_row3", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (filas == 4'b1110) found = 1'b1;
    end
    check("wait_row0", found, 1'b1);
    prev = strobe_cnt;
    force_mask = 4'b0001;
    force_en = 1'b1;
    repeat (3) @(negedge clk);
    force_en = 1'b0;
    @(negedge clk);
    check("glitch_frozen", filas, 4'b1110);
    repeat (4) @(negedge clk);
    check("glitch_resume_row0", filas, 4'b1110);
    repeat (2) @(negedge clk);
    check("glitch_next_row1", filas, 4'b1101);
    repeat (20) @(negedge clk);
    check("glitch_no_strobe", strobe_cnt - prev, 0);

    // Buffer stalled: 'A' is kept, '0' is dropped and flags overrun.
    kif.tx_ready = 1'b0;
    press_key(2'd0, 4'b1000, 4'hA, 8'h41);
    press_key(2'd3, 4'b0010, 4'h0, 8'h30);
    check("ovr_tx_data", kif.tx_data, 8'h41);
    check("ovr_tx_valid", kif.tx_valid, 1'b1);
    check("ovr_overrun", overrun, exp_overrun);
    check("ovr_key_code", key_code, 4'h0);
    kif.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_drained", exp_tx.size(), 0);
    check("ovr_tx_valid_clr", kif.tx_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // Reset while a key is held and a byte is pending.
    kif.tx_ready = 1'b0;
    exp_code.push_back(4'h5);
    exp_tx.push_back(8'h35);
    prev = strobe_cnt;
    press_row = 2'd1; press_mask = 4'b0010; press_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #2;
      if (strobe_cnt != prev) found = 1'b1;
    end
    check("held_strobe_seen", found, 1'b1);
    repeat (3) @(negedge clk);
    check("held_filas", filas, 4'b1101);
    check("held_tx_valid", kif.tx_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_filas", filas, 4'b1110);
    check("arst_tx_valid", kif.tx_valid, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    check("arst_key_code", key_code, 4'h0);
    check("arst_tx_data", kif.tx_data, 8'h30);
    exp_tx.delete();
    press_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("end_code_queue", exp_code.size(), 0);
    check("end_tx_queue", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
